// File: rtl/bist_pkg.sv
// Shared types for the BIST engine: FSM state encoding and counter sizing.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    COMPARE,
    PASS,
    FAIL
  } bist_state_e;

  // Width needed to hold values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bist_engine_if.sv
// Pattern/response bus between the BIST engine and the DUT input mux.
interface bist_engine_if #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 5
);
  // bist_en qualifies pat_out (1 = the mux routes pat_out into the DUT);
  // dut_rsp has no handshake and is sampled DUT_LAT cycles after its pattern.
  logic [IN_W-1:0]  pat_out;
  logic             bist_en;
  logic [OUT_W-1:0] dut_rsp;

  modport master (output pat_out, output bist_en, input dut_rsp);
  modport slave  (input pat_out, input bist_en, output dut_rsp);
endinterface

// File: rtl/bist_lfsr.sv
// Galois shift register with parallel XOR input; serves as pattern LFSR and as MISR.
module bist_lfsr #(
  parameter int             W    = 9,
  parameter logic [W-1:0]   POLY = '0,
  parameter logic [W-1:0]   SEED = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_step,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;
  logic [W-1:0] w_next;

  always_comb begin
    w_next = {r_q[W-2:0], 1'b0} ^ (r_q[W-1] ? POLY : '0) ^ i_din;
  end

  always_ff @(posedge clock) begin
    if (!reset || i_load) begin
      r_q <= SEED;
    end else if (i_step) begin
      r_q <= w_next;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/bist_engine.sv
// BIST engine: LFSR patterns into the DUT, MISR compaction, golden compare.
// Optional BIST_SIG_OUT_EN adds a 'signature' port with the final MISR value.
module bist_engine
  import bist_pkg::*;
#(
  parameter int                IN_W       = 9,
  parameter int                LFSR_W     = 9,
  parameter logic [LFSR_W-1:0] LFSR_POLY  = 9'h011,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 9'h1FF,
  parameter int                OUT_W      = 5,
  parameter logic [OUT_W-1:0]  MISR_POLY  = 5'h05,
  parameter int                PAT_COUNT  = 511,
  parameter int                DUT_LAT    = 0,
  parameter logic [OUT_W-1:0]  GOLDEN_SIG = 5'h1A
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                test_mode,
  bist_engine_if.master       dut_if,
  output logic                busy,
  output logic                done,
  output logic                error,
`ifdef BIST_SIG_OUT_EN
  output logic [OUT_W-1:0]    signature,
`endif
  output bist_state_e         dbg_state
);

  localparam int CNT_W = cnt_width(PAT_COUNT);

  bist_state_e       r_state;
  bist_state_e       w_next_state;
  logic [CNT_W-1:0]  r_count;
  logic [3:0]        r_drain_cnt;
  logic              w_bist_en;
  logic              w_cap_vld;
  logic              w_idle;
  logic [LFSR_W-1:0] w_lfsr;
  logic [OUT_W-1:0]  w_misr;

  assign w_idle    = (r_state == IDLE);
  assign dbg_state = r_state;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count     <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (r_state == RUN) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_idle) begin
        r_count <= '0;
      end
      if (r_state == DRAIN) begin
        r_drain_cnt <= r_drain_cnt + 4'd1;
      end else begin
        r_drain_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_bist_en    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    case (r_state)
      IDLE: begin
        if (test_mode) w_next_state = RUN;
      end
      RUN: begin
        w_bist_en = 1'b1;
        busy      = 1'b1;
        if (!test_mode) begin
          w_next_state = IDLE;
        end else if (r_count == CNT_W'(PAT_COUNT - 1)) begin
          w_next_state = (DUT_LAT > 0) ? DRAIN : COMPARE;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (!test_mode) begin
          w_next_state = IDLE;
        end else if (r_drain_cnt == 4'(DUT_LAT - 1)) begin
          w_next_state = COMPARE;
        end
      end
      COMPARE: begin
        // test_mode is deliberately ignored here so a verdict is always reached.
        busy         = 1'b1;
        w_next_state = (w_misr == GOLDEN_SIG) ? PASS : FAIL;
      end
      PASS: begin
        done = 1'b1;
        if (!test_mode) w_next_state = IDLE;
      end
      FAIL: begin
        done  = 1'b1;
        error = 1'b1;
      end
      default: w_next_state = IDLE;
    endcase
  end

  generate
    if (DUT_LAT == 0) begin : g_no_lat
      assign w_cap_vld = w_bist_en;
    end else begin : g_lat
      logic [DUT_LAT-1:0] r_lat_pipe;
      // Cleared in IDLE so an aborted run cannot leak captures into the next one.
      always_ff @(posedge clock) begin
        if (!reset || w_idle) begin
          r_lat_pipe <= '0;
        end else begin
          r_lat_pipe <= (r_lat_pipe << 1) | DUT_LAT'(w_bist_en);
        end
      end
      assign w_cap_vld = r_lat_pipe[DUT_LAT-1];
    end
  endgenerate

  bist_lfsr #(.W(LFSR_W), .POLY(LFSR_POLY), .SEED(LFSR_SEED)) u_pat_lfsr (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_idle),
    .i_step (w_bist_en),
    .i_din  ('0),
    .o_q    (w_lfsr)
  );

  bist_lfsr #(.W(OUT_W), .POLY(MISR_POLY), .SEED('0)) u_misr (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_idle),
    .i_step (w_cap_vld),
    .i_din  (dut_if.dut_rsp),
    .o_q    (w_misr)
  );

  assign dut_if.pat_out = w_lfsr[IN_W-1:0];
  assign dut_if.bist_en = w_bist_en;

`ifdef BIST_SIG_OUT_EN
  logic [OUT_W-1:0] r_sig;
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sig <= '0;
    end else if (r_state == COMPARE) begin
      r_sig <= w_misr;
    end else if (w_idle && test_mode) begin
      r_sig <= '0;
    end
  end
  assign signature = r_sig;
`endif

endmodule

// File: tb/tb_bist_engine.sv
// Directed bench for bist_engine: pass, fault, latency, abort, mid-run reset, min config.
module tb_bist_engine;
  import bist_pkg::*;

  function automatic logic [4:0] adder(input logic [8:0] p, input logic flt);
    logic [4:0] s;
    s = {1'b0, p[7:4]} + {1'b0, p[3:0]} + {4'b0, p[8]};
    if (flt) s[0] = 1'b0;
    return s;
  endfunction

  function automatic logic [8:0] lfsr_nx(input logic [8:0] y);
    return {y[7:0], 1'b0} ^ (y[8] ? 9'h011 : 9'h000);
  endfunction

  function automatic logic [4:0] misr_nx(input logic [4:0] m, input logic [4:0] d);
    return {m[3:0], 1'b0} ^ (m[4] ? 5'h05 : 5'h00) ^ d;
  endfunction

  function automatic logic [4:0] model_sig(input int n, input logic flt);
    logic [8:0] l;
    logic [4:0] m;
    l = 9'h1FF;
    m = 5'h00;
    for (int i = 0; i < n; i++) begin
      m = misr_nx(m, adder(l, flt));
      l = lfsr_nx(l);
    end
    return m;
  endfunction

  localparam logic [4:0] GOLD = model_sig(511, 1'b0);

  // clock / reset block
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_n   [3];
  logic        tm      [3];
  logic        fault;
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        err_v   [3];
  logic        en_v    [3];
  logic [8:0]  pat_v   [3];
  logic [4:0]  sig_v   [3];
  bist_state_e st_v    [3];

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] pat_q[$];
  logic [8:0] exp_q[$];

  bist_engine_if #(.IN_W(9), .OUT_W(5)) if_a ();
  bist_engine_if #(.IN_W(9), .OUT_W(5)) if_b ();
  bist_engine_if #(.IN_W(9), .OUT_W(5)) if_c ();

  logic [4:0] b_p1, b_p2, b_p3;
  always @(posedge clock) begin
    b_p1 <= adder(if_b.pat_out, 1'b0);
    b_p2 <= b_p1;
    b_p3 <= b_p2;
  end

  assign if_a.dut_rsp = adder(if_a.pat_out, fault);
  assign if_b.dut_rsp = b_p3;
  assign if_c.dut_rsp = adder(if_c.pat_out, 1'b0);

  assign pat_v[0] = if_a.pat_out;
  assign pat_v[1] = if_b.pat_out;
  assign pat_v[2] = if_c.pat_out;
  assign en_v[0]  = if_a.bist_en;
  assign en_v[1]  = if_b.bist_en;
  assign en_v[2]  = if_c.bist_en;

`ifndef BIST_SIG_OUT_EN
  assign sig_v[0] = 5'h00;
  assign sig_v[1] = 5'h00;
  assign sig_v[2] = 5'h00;
`endif

  bist_engine #(.GOLDEN_SIG(GOLD)) u_dut_a (
    .clock(clock), .reset(rst_n[0]), .test_mode(tm[0]), .dut_if(if_a),
    .busy(busy_v[0]), .done(done_v[0]), .error(err_v[0]),
`ifdef BIST_SIG_OUT_EN
    .signature(sig_v[0]),
`endif
    .dbg_state(st_v[0])
  );

  bist_engine #(.DUT_LAT(3), .GOLDEN_SIG(GOLD)) u_dut_b (
    .clock(clock), .reset(rst_n[1]), .test_mode(tm[1]), .dut_if(if_b),
    .busy(busy_v[1]), .done(done_v[1]), .error(err_v[1]),
`ifdef BIST_SIG_OUT_EN
    .signature(sig_v[1]),
`endif
    .dbg_state(st_v[1])
  );

  bist_engine #(.PAT_COUNT(1), .DUT_LAT(0), .GOLDEN_SIG(5'h1F)) u_dut_c (
    .clock(clock), .reset(rst_n[2]), .test_mode(tm[2]), .dut_if(if_c),
    .busy(busy_v[2]), .done(done_v[2]), .error(err_v[2]),
`ifdef BIST_SIG_OUT_EN
    .signature(sig_v[2]),
`endif
    .dbg_state(st_v[2])
  );

  // driver tasks
  task automatic pulse_reset(input int which);
    @(negedge clock);
    rst_n[which] = 1'b0;
    tm[which]    = 1'b0;
    @(posedge clock);
    @(negedge clock);
    rst_n[which] = 1'b1;
  endtask

  // Raises test_mode so the next posedge is edge 0; done_edge stays -1 if the budget runs out.
  task automatic run_to_done(input int which, input int budget,
                             output int done_edge, output int en_cycles, output int busy_only);
    pat_q.delete();
    done_edge = -1;
    en_cycles = 0;
    busy_only = 0;
    @(negedge clock);
    tm[which] = 1'b1;
    @(posedge clock);
    for (int e = 0; e < budget; e++) begin
      @(negedge clock);
      if (done_v[which]) begin
        done_edge = e;
        break;
      end
      if (en_v[which]) begin
        en_cycles++;
        pat_q.push_back(pat_v[which]);
      end else if (busy_v[which]) begin
        busy_only++;
      end
      @(posedge clock);
    end
  endtask

  task automatic test_reset();
    fault = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0;
      tm[i]    = 1'b0;
    end
    tm[0] = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_tests++; if (st_v[0] !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", st_v[0], IDLE); end
    n_tests++; if (pat_v[0] !== 9'h1FF) begin n_fail++; $display("FAIL reset_pat: got %h want 1ff", pat_v[0]); end
    n_tests++; if (en_v[0] !== 1'b0) begin n_fail++; $display("FAIL reset_bist_en: got %b want 0", en_v[0]); end
    n_tests++; if (busy_v[0] !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_v[0]); end
    n_tests++; if (done_v[0] !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_v[0]); end
    n_tests++; if (err_v[0] !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", err_v[0]); end
    n_tests++; if (sig_v[0] !== 5'h00) begin n_fail++; $display("FAIL reset_sig: got %h want 00", sig_v[0]); end
    n_tests++; if (st_v[1] !== IDLE || st_v[2] !== IDLE) begin n_fail++; $display("FAIL reset_state_bc: got %0d/%0d want %0d", st_v[1], st_v[2], IDLE); end
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    tm[0] = 1'b0;
    @(posedge clock);
    @(negedge clock);
    n_tests++; if (st_v[0] !== IDLE) begin n_fail++; $display("FAIL idle_hold: got %0d want %0d", st_v[0], IDLE); end
  endtask

  task automatic test_pass_run();
    int de, en, bo, mism;
    logic [8:0] l;
    fault = 1'b0;
    run_to_done(0, 600, de, en, bo);
    n_tests++; if (de !== 512) begin n_fail++; $display("FAIL pass_done_edge: got %0d want 512", de); end
    n_tests++; if (en !== 511) begin n_fail++; $display("FAIL pass_en_cycles: got %0d want 511", en); end
    n_tests++; if (bo !== 1) begin n_fail++; $display("FAIL pass_compare_cycles: got %0d want 1", bo); end
    n_tests++; if (err_v[0] !== 1'b0) begin n_fail++; $display("FAIL pass_error: got %b want 0", err_v[0]); end
    mism = 0;
    l = 9'h1FF;
    for (int i = 0; i < pat_q.size(); i++) begin
      if (pat_q[i] !== l) mism++;
      l = lfsr_nx(l);
    end
    n_tests++; if (mism !== 0) begin n_fail++; $display("FAIL pass_patterns: got %0d bad patterns want 0", mism); end
`ifdef BIST_SIG_OUT_EN
    n_tests++; if (sig_v[0] !== GOLD) begin n_fail++; $display("FAIL pass_signature: got %h want %h", sig_v[0], GOLD); end
`endif
    repeat (5) @(posedge clock);
    @(negedge clock);
    n_tests++; if (done_v[0] !== 1'b1 || st_v[0] !== PASS) begin n_fail++; $display("FAIL pass_hold: got done=%b st=%0d want done=1 st=%0d", done_v[0], st_v[0], PASS); end
    tm[0] = 1'b0;
    @(posedge clock);
    @(negedge clock);
    n_tests++; if (done_v[0] !== 1'b0 || st_v[0] !== IDLE) begin n_fail++; $display("FAIL pass_release: got done=%b st=%0d want done=0 st=%0d", done_v[0], st_v[0], IDLE); end
  endtask

  task automatic test_fault_run();
    int de, en, bo;
    logic exp_err;
    exp_err = (model_sig(511, 1'b1) !== GOLD);
    fault = 1'b1;
    run_to_done(0, 600, de, en, bo);
    n_tests++; if (de !== 512) begin n_fail++; $display("FAIL fault_done_edge: got %0d want 512", de); end
    n_tests++; if (err_v[0] !== exp_err) begin n_fail++; $display("FAIL fault_error: got %b want %b", err_v[0], exp_err); end
    tm[0] = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_tests++; if (done_v[0] !== exp_err || err_v[0] !== exp_err) begin n_fail++; $display("FAIL fault_sticky: got done=%b err=%b want %b", done_v[0], err_v[0], exp_err); end
    pulse_reset(0);
    fault = 1'b0;
    n_tests++; if (done_v[0] !== 1'b0 || err_v[0] !== 1'b0) begin n_fail++; $display("FAIL fault_clear: got done=%b err=%b want 0", done_v[0], err_v[0]); end
  endtask

  task automatic test_latency();
    int de, en, bo;
    run_to_done(1, 600, de, en, bo);
    n_tests++; if (de !== 515) begin n_fail++; $display("FAIL lat_done_edge: got %0d want 515", de); end
    n_tests++; if (en !== 511) begin n_fail++; $display("FAIL lat_en_cycles: got %0d want 511", en); end
    n_tests++; if (bo !== 4) begin n_fail++; $display("FAIL lat_drain_compare: got %0d want 4", bo); end
    n_tests++; if (err_v[1] !== 1'b0) begin n_fail++; $display("FAIL lat_error: got %b want 0", err_v[1]); end
    tm[1] = 1'b0;
    @(posedge clock);
  endtask

  task automatic test_abort();
    int de, en, bo, mism;
    exp_q.delete();
    @(negedge clock);
    tm[0] = 1'b1;
    @(posedge clock);
    for (int e = 0; e < 100; e++) begin
      @(negedge clock);
      exp_q.push_back(pat_v[0]);
      if (e == 99) tm[0] = 1'b0;
      @(posedge clock);
    end
    @(negedge clock);
    n_tests++; if (st_v[0] !== IDLE || en_v[0] !== 1'b0) begin n_fail++; $display("FAIL abort_state: got st=%0d en=%b want st=%0d en=0", st_v[0], en_v[0], IDLE); end
    n_tests++; if (done_v[0] !== 1'b0 || err_v[0] !== 1'b0) begin n_fail++; $display("FAIL abort_result: got done=%b err=%b want 0", done_v[0], err_v[0]); end
    n_tests++; if (exp_q[0] !== 9'h1FF || exp_q[1] !== 9'h1EF) begin n_fail++; $display("FAIL abort_first_pats: got %h %h want 1ff 1ef", exp_q[0], exp_q[1]); end
    @(posedge clock);
    run_to_done(0, 600, de, en, bo);
    mism = 0;
    for (int i = 0; i < 100; i++) begin
      if (pat_q.size() <= i || pat_q[i] !== exp_q[i]) mism++;
    end
    n_tests++; if (mism !== 0) begin n_fail++; $display("FAIL abort_rerun_pats: got %0d differing want 0", mism); end
    n_tests++; if (de !== 512 || err_v[0] !== 1'b0) begin n_fail++; $display("FAIL abort_rerun: got edge=%0d err=%b want 512/0", de, err_v[0]); end
    tm[0] = 1'b0;
    @(posedge clock);
  endtask

  task automatic test_mid_reset();
    int de, en, bo;
    @(negedge clock);
    tm[0] = 1'b1;
    @(posedge clock);
    for (int e = 0; e < 50; e++) begin
      @(negedge clock);
      if (e == 49) rst_n[0] = 1'b0;
      @(posedge clock);
    end
    @(negedge clock);
    n_tests++; if (st_v[0] !== IDLE || busy_v[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got st=%0d busy=%b want st=%0d busy=0", st_v[0], busy_v[0], IDLE); end
    n_tests++; if (pat_v[0] !== 9'h1FF) begin n_fail++; $display("FAIL midrst_pat: got %h want 1ff", pat_v[0]); end
    n_tests++; if (u_dut_a.w_misr !== 5'h00) begin n_fail++; $display("FAIL midrst_misr: got %h want 00", u_dut_a.w_misr); end
    rst_n[0] = 1'b1;
    tm[0]    = 1'b0;
    @(posedge clock);
    run_to_done(0, 600, de, en, bo);
    n_tests++; if (de !== 512 || err_v[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_rerun: got edge=%0d err=%b want 512/0", de, err_v[0]); end
    tm[0] = 1'b0;
    @(posedge clock);
  endtask

  task automatic test_min_config();
    int de, en, bo;
    run_to_done(2, 20, de, en, bo);
    n_tests++; if (de !== 2) begin n_fail++; $display("FAIL min_done_edge: got %0d want 2", de); end
    n_tests++; if (en !== 1) begin n_fail++; $display("FAIL min_en_cycles: got %0d want 1", en); end
    n_tests++; if (pat_q.size() < 1 || pat_q[0] !== 9'h1FF) begin n_fail++; $display("FAIL min_pattern: got %0d entries want one 1ff", pat_q.size()); end
    n_tests++; if (err_v[2] !== 1'b0) begin n_fail++; $display("FAIL min_error: got %b want 0", err_v[2]); end
`ifdef BIST_SIG_OUT_EN
    n_tests++; if (sig_v[2] !== 5'h1F) begin n_fail++; $display("FAIL min_signature: got %h want 1f", sig_v[2]); end
`endif
    tm[2] = 1'b0;
    @(posedge clock);
  endtask

  initial begin
    test_reset();
    test_pass_run();
    test_fault_run();
    test_latency();
    test_abort();
    test_mid_reset();
    test_min_config();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bist_engine.md
Name: bist_engine

Overview:
- Parametrised built-in self-test engine, successor to the fixed 4-bit adder BIST controller.
- Generates pseudo-random patterns with an internal LFSR and presents them to the DUT.
- Compacts DUT responses in a MISR and compares the final signature to a golden value.
- Adds a configurable DUT pipeline latency (drain phase), abort on test_mode drop, and a held PASS result; sits beside the DUT input mux, driving its select.

Parameters:
- IN_W, 9, DUT stimulus width in bits (pattern bus width).
- LFSR_W, 9, pattern LFSR width; must be >= IN_W.
- LFSR_POLY, 9'h011, Galois feedback taps of the pattern LFSR.
- LFSR_SEED, 9'h1FF, LFSR value loaded on reset and on every IDLE cycle; must be non-zero.
- OUT_W, 5, DUT response width, which is also the MISR width.
- MISR_POLY, 5'h05, Galois feedback taps of the MISR.
- PAT_COUNT, 511, patterns applied per run; must be >= 1.
- DUT_LAT, 0, DUT response latency in clock cycles, 0..15.
- GOLDEN_SIG, 5'h1A, expected final MISR value.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- test_mode  in  1  level request to run BIST; low aborts a run.
- dut_rsp  in  OUT_W  DUT response bus.
- pat_out  out  IN_W  stimulus to the DUT mux: LFSR bits [IN_W-1:0].
- bist_en  out  1  DUT mux select; 1 = pat_out drives the DUT.
- busy  out  1  high in RUN, DRAIN and COMPARE.
- done  out  1  result valid.
- error  out  1  signature mismatch.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low. While reset==0 at a posedge: state=IDLE, LFSR=LFSR_SEED, MISR=0, count=0, latency pipe=0. All outputs are 0 except pat_out=LFSR_SEED[IN_W-1:0].
- LFSR step: next = {y[W-2:0],1'b0} ^ (y[W-1] ? POLY : 0). The LFSR steps only when bist_en=1.
- MISR step: same Galois rule on the MISR register, then XOR with dut_rsp. It steps only when cap_vld=1.
- cap_vld: bist_en delayed by DUT_LAT cycles through a shift register. With DUT_LAT=0, cap_vld equals bist_en combinationally.
- count: width $clog2(PAT_COUNT+1). Increments each RUN cycle and clears in IDLE.
- IDLE: LFSR reloads the seed, MISR clears, count clears. test_mode=1 → RUN.
- RUN: bist_en=1, busy=1.
  - When count==PAT_COUNT-1 → DRAIN if DUT_LAT>0, else → COMPARE.
  - test_mode=0 → IDLE (abort); done and error stay 0.
- DRAIN: bist_en=0, busy=1. Lasts exactly DUT_LAT cycles; the MISR keeps capturing the in-flight responses. Then → COMPARE. test_mode=0 → IDLE (abort).
- COMPARE: busy=1 for one cycle. MISR==GOLDEN_SIG → PASS, else → FAIL. test_mode is ignored in this cycle.
- PASS: done=1, held while test_mode=1. test_mode=0 → IDLE, so a rerun needs a fresh 0→1 on test_mode.
- FAIL: done=1, error=1; sticky until reset, regardless of test_mode.
- Timing: done rises on the edge PAT_COUNT+DUT_LAT+1 edges after the edge that samples test_mode=1 in IDLE.
- Exactly PAT_COUNT patterns are applied. Each run starts from LFSR_SEED, so runs are deterministic.
- Reset mid-run: immediate return to the reset values, with no partial result.
- Simultaneous reset and test_mode: reset wins.

Optional Feature:
- Macro: BIST_SIG_OUT_EN.
- Defined: adds output port signature [OUT_W-1:0], driving the MISR value registered on entry to PASS or FAIL. It holds until the next entry to RUN or reset and reads 0 after reset. Used for golden-value characterisation.
- Undefined: no signature port, no extra register; all other behaviour is identical.

Decomposition:
- Shared package bist_pkg holds:
  - the state encoding enum: IDLE, RUN, DRAIN, COMPARE, PASS, FAIL;
  - a localparam function for the counter width.
- One sub-module, bist_lfsr: parametrised Galois register with W, POLY, SEED, step enable, parallel XOR input din, and load.
  - Instanced twice: as the pattern LFSR with din=0, and as the MISR with din=dut_rsp and SEED=0.

Test Plan:
- Pass run: defaults, DUT = 4-bit adder {c_out,sum}=a+b+c_in fed {c_in,a,b}=pat_out, GOLDEN_SIG from the bench model; test_mode=1 at edge 0 → bist_en high 511 cycles, done=1 at edge 512, error=0, done holds until test_mode=0.
- Fault run: same, with adder bit sum[0] forced 0 → done=1 and error=1 at edge 512; both stay high after test_mode=0; cleared only by reset=0.
- Latency: DUT_LAT=3 with a 3-stage registered adder → bist_en high 511 cycles, DRAIN 3 cycles, done at edge 515, error=0.
- Abort: test_mode dropped at RUN cycle 100 → IDLE next edge, done=0, error=0; rerun gives a pattern sequence identical to the first 100 patterns of the previous run.
- Mid-run reset: reset=0 for one edge at RUN cycle 50 → state IDLE, MISR=0, pat_out=9'h1FF[IN_W-1:0]; a subsequent full run passes.
- Min config: PAT_COUNT=1, DUT_LAT=0 → one pattern = SEED, done at edge 2; with BIST_SIG_OUT_EN, signature equals the MISR after one capture.
